// File: rtl/spi_dac_stream_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_dac_stream_controller_if                                               |
// | Sample stream and SPI pin bundle for the streaming DAC controller.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface spi_dac_stream_controller_if #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int CTRL_BITS    = 4,
  parameter int FIFO_DEPTH   = 16
);
  logic                              enable;
  logic [CTRL_BITS-1:0]              ctrlBits;
  logic [SAMPLE_WIDTH-1:0]           inputSample;
  logic                              inputValid;
  logic                              inputReady;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount;
  logic                              output_SPI_SCLK;
  logic                              output_SPI_SYNC_n;
  logic                              output_SPI_DIN;
  logic                              isBusy;
  logic                              transmitComplete;
  logic                              underflow;
  logic                              overrun;

  modport master (
    output enable, ctrlBits, inputSample, inputValid,
    input  inputReady, fifoCount, output_SPI_SCLK, output_SPI_SYNC_n, output_SPI_DIN,
    input  isBusy, transmitComplete, underflow, overrun
  );

  modport slave (
    input  enable, ctrlBits, inputSample, inputValid,
    output inputReady, fifoCount, output_SPI_SCLK, output_SPI_SYNC_n, output_SPI_DIN,
    output isBusy, transmitComplete, underflow, overrun
  );
endinterface
`default_nettype wire

// File: rtl/spi_dac_stream_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_dac_stream_controller                                                  |
// | FIFO-buffered SPI DAC streamer driven by an internal sample-rate timer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_dac_stream_controller #(
  parameter int SAMPLE_WIDTH  = 12,
  parameter int CTRL_BITS     = 4,
  parameter int FRAME_BITS    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_PERIOD = 1136
) (
  input  logic                         clock_50Mhz,
  input  logic                         reset_n,
  spi_dac_stream_controller_if.slave   bus
);

  localparam int c_ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int c_TIMER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int c_DIV_W   = $clog2(SCLK_DIV + 1);
  localparam int c_HALF_W  = $clog2(2 * FRAME_BITS);
  localparam int c_PAD     = FRAME_BITS - CTRL_BITS - SAMPLE_WIDTH;

  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_LAST   = c_DIV_W'(SCLK_DIV - 1);
  localparam logic [c_HALF_W-1:0]  c_HALF_LAST  = c_HALF_W'(2 * FRAME_BITS - 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_FULL   = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [SAMPLE_WIDTH-1:0] r_fifoMem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]     r_wrPtr;
  logic [c_ADDR_W-1:0]     r_rdPtr;
  logic [c_CNT_W-1:0]      r_count;
  logic                    r_ready;
  logic [SAMPLE_WIDTH-1:0] r_lastSample;
  logic [c_TIMER_W-1:0]    r_timer;
  logic [1:0]              r_state;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [c_DIV_W-1:0]      r_div;
  logic [c_HALF_W-1:0]     r_half;
  logic                    r_sclk;
  logic                    r_syncN;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_underflow;
  logic                    r_overrun;

  logic                    w_tick;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [SAMPLE_WIDTH-1:0] w_sample;
  logic [FRAME_BITS-1:0]   w_frame;
  logic [c_CNT_W-1:0]      w_countNext;

  assign w_tick   = bus.enable && (r_timer == c_TIMER_LAST);
  assign w_empty  = (r_count == '0);
  assign w_push   = bus.inputValid && r_ready;
  assign w_pop    = w_tick && (r_state == c_IDLE) && !w_empty;
  // An empty FIFO replays the previous sample rather than going silent.
  assign w_sample = w_empty ? r_lastSample : r_fifoMem[r_rdPtr];
  assign w_frame  = FRAME_BITS'({bus.ctrlBits, w_sample}) << c_PAD;

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= bus.inputSample;
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_ADDR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + c_ADDR_W'(1);
      end
      r_count <= w_countNext;
      r_ready <= (w_countNext < c_CNT_FULL);
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (!bus.enable || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + c_TIMER_W'(1);
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_IDLE;
      r_shift      <= '0;
      r_div        <= '0;
      r_half       <= '0;
      r_sclk       <= 1'b1;
      r_syncN      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_underflow  <= 1'b0;
      r_overrun    <= 1'b0;
      r_lastSample <= '0;
    end else begin
      r_underflow <= 1'b0;
      // Ticks arriving mid-frame are reported and discarded, never queued.
      r_overrun   <= w_tick && (r_state != c_IDLE);
      case (r_state)
        c_IDLE: begin
          if (w_tick) begin
            r_state      <= c_LOAD;
            r_syncN      <= 1'b0;
            r_sclk       <= 1'b1;
            r_busy       <= 1'b1;
            r_shift      <= w_frame;
            r_lastSample <= w_sample;
            r_underflow  <= w_empty;
          end
        end
        c_LOAD: begin
          r_state <= c_SHIFT;
          r_div   <= '0;
          r_half  <= '0;
        end
        c_SHIFT: begin
          if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Data advances on rising SCLK so it is stable across the DAC's falling-edge sample.
            if (!r_sclk) begin
              r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end
            if (r_half == c_HALF_LAST) begin
              r_state <= c_DONE;
              r_syncN <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_half <= r_half + c_HALF_W'(1);
            end
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.inputReady        = r_ready;
  assign bus.fifoCount         = r_count;
  assign bus.output_SPI_SCLK   = r_sclk;
  assign bus.output_SPI_SYNC_n = r_syncN;
  assign bus.output_SPI_DIN    = r_shift[FRAME_BITS-1];
  assign bus.isBusy            = r_busy;
  assign bus.transmitComplete  = r_done;
  assign bus.underflow         = r_underflow;
  assign bus.overrun           = r_overrun;

endmodule
`default_nettype wire
